// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: next-PC select codes,
// fetch window, fetch FSM encodings and the IF/ID bundle.
package mips_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI   = 32'h0000_6FFF;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } if_id_t;

endpackage

// File: rtl/npc_calc.sv
// Redirect target mux and fetch-address legality check.
// Ports: npc_sel/id_pc4/ext_imm/j_index/jr_target -> target, is_xfer;
//        pc -> pc_bad (misaligned or outside LO..HI).
module npc_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] LO = IMEM_LO,
    parameter logic [31:0] HI = IMEM_HI
) (
    input  logic [1:0]  npc_sel,
    input  logic [31:0] id_pc4,
    input  logic [31:0] ext_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] pc,
    output logic [31:0] target,
    output logic        is_xfer,
    output logic        pc_bad
);

    // Top two immediate bits fall off the word shift.
    logic unused_imm;
    assign unused_imm = ^ext_imm[31:30];

    always_comb begin
        target = id_pc4;
        case (npc_sel)
            NPC_BR:  target = id_pc4 + {ext_imm[29:0], 2'b00};
            NPC_J:   target = {id_pc4[31:28], j_index, 2'b00};
            NPC_JR:  target = jr_target;
            default: target = id_pc4;
        endcase
    end

    assign is_xfer = (npc_sel != NPC_SEQ);

    assign pc_bad = (pc[1:0] != 2'b00) || (pc < LO) || (pc > HI);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, redirect, imem handshake, IF/ID register.
// Ports: clk/reset, stall/flush, redirect bundle, imem req/ack/rvalid,
//        IF/ID outputs (instr, pc, valid, adel).
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] IMEM_LO  = mips_pkg::IMEM_LO,
    parameter logic [31:0] IMEM_HI  = mips_pkg::IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] id_pc4,
    input  logic [31:0] ext_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        if_id_adel
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, pc4;
    logic [31:0]  hold_q, hold_n;
    logic         kill, kill_n;
    if_id_t       ifid_q, ifid_n, bubble;
    logic [31:0]  target;
    logic         is_xfer, pc_bad, take, req_c;

    npc_calc #(.LO(IMEM_LO), .HI(IMEM_HI)) u_npc (
        .npc_sel   (npc_sel),
        .id_pc4    (id_pc4),
        .ext_imm   (ext_imm),
        .j_index   (j_index),
        .jr_target (jr_target),
        .pc        (pc),
        .target    (target),
        .is_xfer   (is_xfer),
        .pc_bad    (pc_bad)
    );

    assign take   = redirect && !stall && is_xfer;
    assign pc4    = pc + 32'd4;
    assign bubble = '{instr: NOP_INSTR, pc: pc, valid: 1'b0, adel: 1'b0};

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        hold_n  = hold_q;
        ifid_n  = stall ? ifid_q : bubble;
        req_c   = 1'b0;
        case (state)
            ST_REQ: begin
                if (pc_bad) begin
                    // Illegal address never reaches memory; the
                    // exception rides down the pipe in its own slot.
                    if (!stall) begin
                        ifid_n = '{instr: NOP_INSTR, pc: pc,
                                   valid: 1'b1, adel: 1'b1};
                        pc_n   = pc4;
                    end
                    if (take) pc_n = target;
                end else begin
                    req_c = 1'b1;
                    if (take) pc_n = target;
                    if (imem_ack) begin
                        state_n = ST_WAIT;
                        // Accepted on the old path: discard on return.
                        kill_n  = take;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill || take) begin
                        kill_n  = 1'b0;
                        state_n = ST_REQ;
                        if (take) pc_n = target;
                    end else if (stall) begin
                        hold_n  = imem_rdata;
                        state_n = ST_HOLD;
                    end else begin
                        ifid_n  = '{instr: imem_rdata, pc: pc,
                                    valid: 1'b1, adel: 1'b0};
                        pc_n    = pc4;
                        state_n = ST_REQ;
                    end
                end else if (take) begin
                    pc_n   = target;
                    kill_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (take) begin
                    pc_n    = target;
                    state_n = ST_REQ;
                end else if (!stall) begin
                    ifid_n  = '{instr: hold_q, pc: pc,
                                valid: 1'b1, adel: 1'b0};
                    pc_n    = pc4;
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_REQ;
        endcase
        if (flush) ifid_n = bubble;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            kill   <= 1'b0;
            hold_q <= NOP_INSTR;
            ifid_q <= '{instr: NOP_INSTR, pc: RESET_PC,
                        valid: 1'b0, adel: 1'b0};
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            kill   <= kill_n;
            hold_q <= hold_n;
            ifid_q <= ifid_n;
        end
    end

    // Request is masked while reset is held so the port is quiet at once.
    assign imem_req    = req_c && !reset;
    assign imem_addr   = pc;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_valid = ifid_q.valid;
    assign if_id_adel  = ifid_q.adel;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed stimulus pushes expected
// fetch addresses and IF/ID slots; negedge monitors pop and compare.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect;
    logic [1:0]  npc_sel;
    logic [31:0] id_pc4, ext_imm, jr_target;
    logic [25:0] j_index;
    logic        imem_req, imem_ack, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc;
    logic        if_id_valid, if_id_adel;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .npc_sel     (npc_sel),
        .id_pc4      (id_pc4),
        .ext_imm     (ext_imm),
        .j_index     (j_index),
        .jr_target   (jr_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .if_id_adel  (if_id_adel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } slot_t;

    slot_t       slot_q[$];
    logic [31:0] addr_q[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h2408_0000 + ((a - 32'h0000_2FFC) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: ack when enabled, rvalid lat cycles after accept.
    logic        ack_en = 1'b0;
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    assign imem_ack    = imem_req && ack_en;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = imem_rvalid ? memword(paddr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
        if (imem_req && imem_ack) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= imem_addr;
        end
    end

    // Monitors
    logic        prev_v = 1'b0;
    slot_t       prev_s = '0;
    slot_t       cur_s, exp_s;
    logic [31:0] exp_a;

    always @(negedge clk) begin
        if (!reset && imem_req && imem_ack) begin
            if (addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ack_unexp: got addr %h want none", imem_addr);
            end else begin
                exp_a = addr_q.pop_front();
                chk("ack_addr", imem_addr, exp_a);
            end
        end
        cur_s = '{pc: if_id_pc, instr: if_id_instr, adel: if_id_adel};
        if (if_id_valid && (!prev_v || cur_s != prev_s)) begin
            if (slot_q.size() == 0) begin
                total++; bad++;
                $display("FAIL slot_unexp: got pc %h instr %h want none",
                         if_id_pc, if_id_instr);
            end else begin
                exp_s = slot_q.pop_front();
                chk("slot_pc", if_id_pc, exp_s.pc);
                chk("slot_instr", if_id_instr, exp_s.instr);
                chk("slot_adel", {31'd0, if_id_adel}, {31'd0, exp_s.adel});
            end
        end
        prev_v = if_id_valid;
        prev_s = cur_s;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] w,
                        input logic adel, input logic with_addr);
        if (with_addr) addr_q.push_back(a);
        slot_q.push_back('{pc: a, instr: w, adel: adel});
    endtask

    task automatic wait_slot(input logic [31:0] p);
        int n = 0;
        while (!(if_id_valid && if_id_pc == p) && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL wait_slot: got no slot want pc %h", p);
        end
    endtask

    task automatic jump(input logic [1:0] sel, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [25:0] idx,
                        input logic [31:0] jr);
        redirect  = 1'b1;
        npc_sel   = sel;
        id_pc4    = pc4;
        ext_imm   = imm;
        j_index   = idx;
        jr_target = jr;
        tick();
        redirect  = 1'b0;
        npc_sel   = 2'b00;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        npc_sel = 2'b00; id_pc4 = '0; ext_imm = '0;
        j_index = '0; jr_target = '0;
        tick(); tick();
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc", if_id_pc, 32'h3000);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_adel", {31'd0, if_id_adel}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h3000);

        // First fetch, 1-cycle memory
        reset = 1'b0;
        push(32'h3000, 32'h2408_0001, 1'b0, 1'b1);
        ack_en = 1'b1;
        wait_slot(32'h3000);
        ack_en = 1'b0;
        chk("seq_addr", imem_addr, 32'h3004);
        chk("seq_req", {31'd0, imem_req}, 32'd1);

        // Branch back and jump, request withdrawn while unacked
        jump(2'b01, 32'h3008, 32'hFFFF_FFFE, 26'd0, 32'd0);
        chk("br_addr", imem_addr, 32'h3000);
        jump(2'b10, 32'h3004, 32'd0, 26'h000_0C10, 32'd0);
        chk("j_addr", imem_addr, 32'h3040);
        chk("j_req", {31'd0, imem_req}, 32'd1);
        push(32'h3040, memword(32'h3040), 1'b0, 1'b1);
        ack_en = 1'b1;
        wait_slot(32'h3040);
        ack_en = 1'b0;

        // Redirect while WAIT on a 3-cycle memory
        lat = 3;
        addr_q.push_back(32'h3044);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        jump(2'b11, 32'd0, 32'd0, 26'd0, 32'h3100);
        chk("kill_addr", imem_addr, 32'h3100);
        lat = 1;
        push(32'h3100, memword(32'h3100), 1'b0, 1'b1);
        ack_en = 1'b1;
        wait_slot(32'h3100);
        ack_en = 1'b0;

        // Stall for 4 cycles while the word returns
        push(32'h3104, memword(32'h3104), 1'b0, 1'b1);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stl_valid", {31'd0, if_id_valid}, 32'd0);
            chk("stl_addr", imem_addr, 32'h3104);
            chk("stl_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstl_pc", if_id_pc, 32'h3104);
        chk("unstl_valid", {31'd0, if_id_valid}, 32'd1);
        chk("unstl_instr", if_id_instr, memword(32'h3104));

        // Illegal fetch addresses: misaligned and above the window
        jump(2'b11, 32'd0, 32'd0, 26'd0, 32'h3002);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        push(32'h3002, 32'h0, 1'b1, 1'b0);
        tick();
        push(32'h3006, 32'h0, 1'b1, 1'b0);
        jump(2'b11, 32'd0, 32'd0, 26'd0, 32'h7000);
        chk("hi_req", {31'd0, imem_req}, 32'd0);
        push(32'h7000, 32'h0, 1'b1, 1'b0);
        tick();
        push(32'h7004, 32'h0, 1'b1, 1'b0);
        jump(2'b11, 32'd0, 32'd0, 26'd0, 32'h3200);
        chk("adel_flag", {31'd0, if_id_adel}, 32'd1);
        chk("adel_valid", {31'd0, if_id_valid}, 32'd1);
        chk("adel_instr", if_id_instr, 32'h0);
        chk("back_addr", imem_addr, 32'h3200);
        chk("back_req", {31'd0, imem_req}, 32'd1);

        // Flush wins over stall, PC held
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
        chk("fl_adel", {31'd0, if_id_adel}, 32'd0);
        chk("fl_instr", if_id_instr, 32'h0);
        chk("fl_addr", imem_addr, 32'h3200);
        stall = 1'b0;
        flush = 1'b0;

        // Async reset in the middle of WAIT
        lat = 3;
        addr_q.push_back(32'h3200);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_addr", imem_addr, 32'h3000);
        chk("ar_pc", if_id_pc, 32'h3000);
        chk("ar_valid", {31'd0, if_id_valid}, 32'd0);
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        chk("ar_instr", if_id_instr, 32'h0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("late_valid", {31'd0, if_id_valid}, 32'd0);
        chk("late_addr", imem_addr, 32'h3000);
        lat = 1;
        push(32'h3000, 32'h2408_0001, 1'b0, 1'b1);
        ack_en = 1'b1;
        wait_slot(32'h3000);
        ack_en = 1'b0;
        tick(); tick();
        chk("sb_drain", addr_q.size() + slot_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
